// File: rtl/loader_ctrl.sv
// loader_ctrl: receives a length-prefixed byte stream, packs it into 32-bit words
// through an external buffer, then drains the buffer to memory and releases the CPU.
`default_nettype none

module loader_ctrl #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          MAX_WORDS = 1024
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        start,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        buf_we,
  output logic [31:0] buf_wd,
  output logic        buf_rd,
  input  logic        buf_rd_valid,
  input  logic [31:0] buf_rd_data,
  output logic        mem_wr_valid,
  output logic [31:0] mem_wr_addr,
  output logic [31:0] mem_wr_data,
  input  logic        mem_wr_ready,
  output logic        busy,
  output logic        load_done,
  output logic        err,
  output logic        cpu_rstn
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_HDR     = 3'd1;
  localparam logic [2:0] S_PAYLOAD = 3'd2;
  localparam logic [2:0] S_DRAIN   = 3'd3;
  localparam logic [2:0] S_DONE    = 3'd4;
  localparam logic [2:0] S_ERR     = 3'd5;

  localparam logic [31:0] c_max_words = 32'(MAX_WORDS);

  logic [2:0]  r_state;
  logic [1:0]  r_byte_cnt;
  logic [31:0] r_asm;
  logic [31:0] r_n;
  logic [31:0] r_wr_cnt;
  logic [31:0] r_rd_cnt;
  logic        r_outst;
  logic        r_buf_we;
  logic [31:0] r_buf_wd;
  logic        r_buf_rd;
  logic        r_mem_valid;
  logic [31:0] r_mem_addr;
  logic [31:0] r_mem_data;

  logic [31:0] w_word;
  logic        w_last_byte;
  logic        w_draining;
  logic        w_complete;
  logic [31:0] w_rd_cnt_nxt;
  logic        w_issue;

  // Bytes shift in from the top so the first byte lands in bits [7:0].
  assign w_word       = {rx_data, r_asm[31:8]};
  assign w_last_byte  = rx_valid && (r_byte_cnt == 2'd3);
  assign w_draining   = (r_state == S_PAYLOAD) || (r_state == S_DRAIN);
  assign w_complete   = r_mem_valid && mem_wr_ready;
  assign w_rd_cnt_nxt = r_rd_cnt + {31'd0, w_complete};
  // Look ahead past a completing write so back-to-back words drain in 3 cycles.
  assign w_issue      = w_draining && (!r_outst || w_complete) && (w_rd_cnt_nxt < r_wr_cnt);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state     <= S_IDLE;
      r_byte_cnt  <= 2'd0;
      r_asm       <= 32'd0;
      r_n         <= 32'd0;
      r_wr_cnt    <= 32'd0;
      r_rd_cnt    <= 32'd0;
      r_outst     <= 1'b0;
      r_buf_we    <= 1'b0;
      r_buf_wd    <= 32'd0;
      r_buf_rd    <= 1'b0;
      r_mem_valid <= 1'b0;
      r_mem_addr  <= 32'd0;
      r_mem_data  <= 32'd0;
    end else begin
      r_buf_we <= 1'b0;
      r_buf_rd <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state    <= S_HDR;
            r_byte_cnt <= 2'd0;
            r_asm      <= 32'd0;
            r_n        <= 32'd0;
            r_wr_cnt   <= 32'd0;
            r_rd_cnt   <= 32'd0;
            r_outst    <= 1'b0;
          end
        end
        S_HDR: begin
          if (rx_valid) begin
            r_asm      <= w_word;
            r_byte_cnt <= r_byte_cnt + 2'd1;
            if (w_last_byte) begin
              r_n <= w_word;
              if (w_word == 32'd0)             r_state <= S_DONE;
              else if (w_word > c_max_words)   r_state <= S_ERR;
              else                             r_state <= S_PAYLOAD;
            end
          end
        end
        S_PAYLOAD: begin
          if (rx_valid) begin
            r_asm      <= w_word;
            r_byte_cnt <= r_byte_cnt + 2'd1;
            if (w_last_byte) begin
              r_buf_we <= 1'b1;
              r_buf_wd <= w_word;
              r_wr_cnt <= r_wr_cnt + 32'd1;
              if ((r_wr_cnt + 32'd1) == r_n) r_state <= S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          if (!r_outst && (r_rd_cnt == r_n)) r_state <= S_DONE;
        end
        default: ;
      endcase

      if (w_draining && r_outst && buf_rd_valid && !r_mem_valid) begin
        r_mem_valid <= 1'b1;
        r_mem_data  <= buf_rd_data;
        r_mem_addr  <= BASE_ADDR + (r_rd_cnt << 2);
      end else if (w_complete) begin
        r_mem_valid <= 1'b0;
        r_rd_cnt    <= r_rd_cnt + 32'd1;
        r_outst     <= 1'b0;
      end

      if (w_issue) begin
        r_buf_rd <= 1'b1;
        r_outst  <= 1'b1;
      end
    end
  end

  assign buf_we       = r_buf_we;
  assign buf_wd       = r_buf_wd;
  assign buf_rd       = r_buf_rd;
  assign mem_wr_valid = r_mem_valid;
  assign mem_wr_addr  = r_mem_addr;
  assign mem_wr_data  = r_mem_data;
  assign busy         = (r_state == S_HDR) || (r_state == S_PAYLOAD) || (r_state == S_DRAIN);
  assign load_done    = (r_state == S_DONE);
  assign err          = (r_state == S_ERR);
  assign cpu_rstn     = (r_state == S_DONE);

endmodule

`default_nettype wire
